projectile_pool_arbiter: RTL and testbench
==========================================

Name: projectile_pool_arbiter

Overview:
- Shared pool of PROJ_SLOTS projectile slots, contended by two requesters: the boss attack sequencer (requester 0) and the player shot logic (requester 1).
- Arbitrates spawn requests round-robin and allocates the lowest free slot.
- On every pulse_cycleStep it advances all live projectiles and retires those that leave the play area or whose beam lifetime expires.
- Sits between the attack sequencer / player controller and the renderer / collision logic, which read slots by index.

Parameters:
- PROJ_SLOTS, 8, number of pool slots (power of 2, ≤16).
- BOSS_SPEED, 4, pixels per step, downward, for boss projectiles.
- PLAYER_SPEED, 6, pixels per step, upward, for player projectiles.
- DIAG_DX, 3, horizontal pixels per step for diagonal projectiles.
- BEAM_LIFE, 30, steps a beam stays alive.
- SCREEN_LEFT, 144, SCREEN_RIGHT, 783, SCREEN_TOP, 35, SCREEN_BOTTOM, 514: visible bounds, inclusive.

Ports:
- clk_master  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pulse_cycleStep  in  1  one-cycle motion tick
- req_valid  in  2  spawn request per requester; [0] boss, [1] player
- req_ready  out  2  grant; combinational, one-hot or zero
- req_x  in  2x10  spawn x per requester
- req_y  in  2x10  spawn y per requester
- req_w  in  2x10  width per requester
- req_h  in  2x9  height per requester
- req_type  in  2x2  00 projectile, 01 beam, 10 diagonal, 11 reserved
- req_dir  in  2  diagonal direction; 1 = right
- kill_valid  in  1  free slot kill_idx (hit consumed)
- kill_idx  in  log2(PROJ_SLOTS)  slot to free
- rd_idx  in  log2(PROJ_SLOTS)  readout index
- rd_valid, rd_owner  out  1 each  slot live; owner (0 boss, 1 player)
- rd_x, rd_y, rd_w  out  10 each
- rd_h  out  9
- rd_type  out  2
- active_mask  out  PROJ_SLOTS  live slots
- free_count  out  log2(PROJ_SLOTS)+1  number of empty slots

Behaviour:
- Reset (async assert, sync release): all slots invalid, rd_* = 0, active_mask = 0, free_count = PROJ_SLOTS, rr_last = 1 (boss wins first contention).
- Handshake: a request transfers in the cycle where req_valid[i] && req_ready[i].
  - req_ready is 0 for both requesters when no slot is free.
  - At most one grant per cycle.
  - Under contention, grant the requester that is not rr_last; rr_last updates only on a granted cycle.
  - With a single requester, grant it whenever a slot is free.
- Allocation: the lowest-index slot that is invalid at the start of the cycle.
  - The slot is written the next edge with the request fields and owner = i.
  - Beam life counter is set to BEAM_LIFE.
  - Type 11 is granted but discarded; no slot is written.
- Step (pulse_cycleStep = 1), applied to each slot valid at the start of the cycle; a slot allocated in the same cycle is not stepped.
  - Boss, type 00: y += BOSS_SPEED. Retire if the new y > SCREEN_BOTTOM.
  - Diagonal, type 10: y as type 00; x ± DIAG_DX. Retire if x would fall below SCREEN_LEFT or x + w would exceed SCREEN_RIGHT.
  - Player, types 00/10: y -= PLAYER_SPEED. Retire if y < SCREEN_TOP + PLAYER_SPEED; no underflow permitted.
  - Beam, type 01: position fixed; life decrements; retire when life reaches 1 on a step.
- Arithmetic: all position math is 11-bit unsigned to avoid wrap.
- Kill: frees kill_idx at the next edge.
  - Kill beats step on the same slot.
  - Kill of an invalid slot is ignored.
  - A killed slot is not allocatable in the same cycle (free status is sampled pre-edge).
- Readout: registered, with 1-cycle latency from rd_idx.
  - Reflects slot state after the edge in which rd_idx was sampled; invalid slots read as all zero.
- active_mask and free_count are registered and consistent with the slot state.

Decomposition:
- Shared package game_pkg holds:
  - attack type codes ATK_PROJ, ATK_BEAM, ATK_DIAG;
  - screen bound constants;
  - owner codes OWN_BOSS, OWN_PLAYER.
- One sub-module, proj_slot: a single slot's state, step and retire logic and its life counter, instantiated PROJ_SLOTS times.
- Arbiter, priority encoder and readout mux live in the top.

Test Plan:
- Reset mid-operation: fill 3 slots, pulse rst_n low → active_mask = 0, free_count = 8, and rd_valid = 0 at all indices without waiting for a clock edge.
- Contention: both requesters valid for 4 cycles with an empty pool → grants alternate boss, player, boss, player; slots 0..3 have owner 0, 1, 0, 1.
- Full pool: 8 boss spawns, then a 9th → req_ready = 0 and free_count = 0; kill_idx = 5 → next cycle slot 5 is freed; the 10th request lands in slot 5.
- Motion and retire: boss spawn at y = 508, type 00; step → y = 512, still live; next step → 516 > 514, so the slot retires. Player spawn at y = 40; step → retired (40 < 41).
- Beam lifetime: beam spawn; 29 steps → still live; 30th step → retired. Kill and step on the same cycle → slot freed, with no step applied.
- Diagonal right at x = 770, w = 10, DIAG_DX = 3: first step → x = 773, still live (773 + 10 = 783); second step → retired (776 + 10 = 786 > 783).

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared attack codes, owner codes, screen bounds and the
//               per-slot record type for the projectile pool.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    localparam logic [1:0] ATK_PROJ = 2'b00;
    localparam logic [1:0] ATK_BEAM = 2'b01;
    localparam logic [1:0] ATK_DIAG = 2'b10;
    localparam logic [1:0] ATK_RSVD = 2'b11;

    localparam logic OWN_BOSS   = 1'b0;
    localparam logic OWN_PLAYER = 1'b1;

    // Visible play area, inclusive, held at 11 bits so step math cannot wrap
    localparam logic [10:0] SCREEN_LEFT   = 11'd144;
    localparam logic [10:0] SCREEN_RIGHT  = 11'd783;
    localparam logic [10:0] SCREEN_TOP    = 11'd35;
    localparam logic [10:0] SCREEN_BOTTOM = 11'd514;

    typedef struct packed {
        logic       valid;
        logic       owner;
        logic [1:0] kind;
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] w;
        logic [8:0] h;
    } slot_t;

endpackage
`default_nettype wire

// File: rtl/proj_slot.sv
`default_nettype none
// ============================================================================
// Module      : proj_slot
// Description : One pool slot: holds a projectile, moves it on each step and
//               retires it when it leaves the play area or its beam expires.
// Revision    : 1.0 - initial release
// ============================================================================
module proj_slot
    import game_pkg::*;
#(
    parameter int BOSS_SPEED   = 4,
    parameter int PLAYER_SPEED = 6,
    parameter int DIAG_DX      = 3,
    parameter int BEAM_LIFE    = 30
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_alloc,
    input  slot_t i_alloc_slot,
    input  logic  i_alloc_dir,
    input  logic  i_kill,
    input  logic  i_step,
    output logic  o_valid_q,
    output slot_t o_slot_d
);

    localparam int LIFE_W = $clog2(BEAM_LIFE + 1);

    slot_t             r_slot_q;
    slot_t             w_slot_d;
    logic              r_dir_q;
    logic              w_dir_d;
    logic [LIFE_W-1:0] r_life_q;
    logic [LIFE_W-1:0] w_life_d;
    logic [10:0]       w_y_down;
    logic [11:0]       w_right_edge;

    always_comb begin
        w_slot_d     = r_slot_q;
        w_dir_d      = r_dir_q;
        w_life_d     = r_life_q;
        w_y_down     = {1'b0, r_slot_q.y} + 11'(BOSS_SPEED);
        w_right_edge = {2'b00, r_slot_q.x} + {2'b00, r_slot_q.w} + 12'(DIAG_DX);
        if (r_slot_q.valid) begin
            // A kill consumes the slot outright; no motion is applied
            if (i_kill) begin
                w_slot_d.valid = 1'b0;
            end else if (i_step) begin
                if (r_slot_q.kind == ATK_BEAM) begin
                    if (r_life_q <= LIFE_W'(1)) begin
                        w_slot_d.valid = 1'b0;
                    end else begin
                        w_life_d = r_life_q - LIFE_W'(1);
                    end
                end else if (r_slot_q.owner == OWN_PLAYER) begin
                    if ({1'b0, r_slot_q.y} < 11'(SCREEN_TOP + 11'(PLAYER_SPEED))) begin
                        w_slot_d.valid = 1'b0;
                    end else begin
                        w_slot_d.y = r_slot_q.y - 10'(PLAYER_SPEED);
                    end
                end else begin
                    w_slot_d.y = w_y_down[9:0];
                    if (w_y_down > SCREEN_BOTTOM) begin
                        w_slot_d.valid = 1'b0;
                    end
                    if (r_slot_q.kind == ATK_DIAG) begin
                        if (r_dir_q) begin
                            w_slot_d.x = r_slot_q.x + 10'(DIAG_DX);
                            if (w_right_edge > {1'b0, SCREEN_RIGHT}) begin
                                w_slot_d.valid = 1'b0;
                            end
                        end else begin
                            w_slot_d.x = r_slot_q.x - 10'(DIAG_DX);
                            if ({1'b0, r_slot_q.x} < 11'(SCREEN_LEFT + 11'(DIAG_DX))) begin
                                w_slot_d.valid = 1'b0;
                            end
                        end
                    end
                end
            end
        end else if (i_alloc) begin
            w_slot_d = i_alloc_slot;
            w_dir_d  = i_alloc_dir;
            w_life_d = LIFE_W'(BEAM_LIFE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_q <= '0;
            r_dir_q  <= 1'b0;
            r_life_q <= '0;
        end else begin
            r_slot_q <= w_slot_d;
            r_dir_q  <= w_dir_d;
            r_life_q <= w_life_d;
        end
    end

    assign o_valid_q = r_slot_q.valid;
    assign o_slot_d  = w_slot_d;

endmodule
`default_nettype wire

// File: rtl/projectile_pool_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : projectile_pool_arbiter
// Description : Round-robin spawn arbiter for boss/player requesters over a
//               pool of projectile slots, with registered indexed readout.
// Revision    : 1.0 - initial release
// ============================================================================
module projectile_pool_arbiter
    import game_pkg::*;
#(
    parameter int PROJ_SLOTS   = 8,
    parameter int BOSS_SPEED   = 4,
    parameter int PLAYER_SPEED = 6,
    parameter int DIAG_DX      = 3,
    parameter int BEAM_LIFE    = 30
) (
    input  logic                          clk_master,
    input  logic                          rst_n,
    input  logic                          pulse_cycleStep,
    input  logic [1:0]                    req_valid,
    output logic [1:0]                    req_ready,
    input  logic [1:0][9:0]               req_x,
    input  logic [1:0][9:0]               req_y,
    input  logic [1:0][9:0]               req_w,
    input  logic [1:0][8:0]               req_h,
    input  logic [1:0][1:0]               req_type,
    input  logic [1:0]                    req_dir,
    input  logic                          kill_valid,
    input  logic [$clog2(PROJ_SLOTS)-1:0] kill_idx,
    input  logic [$clog2(PROJ_SLOTS)-1:0] rd_idx,
    output logic                          rd_valid,
    output logic                          rd_owner,
    output logic [9:0]                    rd_x,
    output logic [9:0]                    rd_y,
    output logic [9:0]                    rd_w,
    output logic [8:0]                    rd_h,
    output logic [1:0]                    rd_type,
    output logic [PROJ_SLOTS-1:0]         active_mask,
    output logic [$clog2(PROJ_SLOTS):0]   free_count
);

    localparam int IDX_W = $clog2(PROJ_SLOTS);
    localparam int CNT_W = IDX_W + 1;

    logic [PROJ_SLOTS-1:0] w_valid_q;
    logic [PROJ_SLOTS-1:0] w_valid_d;
    slot_t                 w_slot_d [PROJ_SLOTS];
    logic                  w_any_free;
    logic [IDX_W-1:0]      w_free_idx;
    logic                  w_gnt;
    logic                  w_alloc_en;
    slot_t                 w_alloc_slot;
    logic                  r_rr_last_q;
    logic                  w_rr_last_d;
    slot_t                 r_rd_q;
    slot_t                 w_rd_d;
    logic [CNT_W-1:0]      r_free_count_q;
    logic [CNT_W-1:0]      w_free_count_d;

    // Lowest-index empty slot, sampled on pre-edge state so a slot being
    // killed this cycle is not reused until the following one
    always_comb begin
        w_any_free = 1'b0;
        w_free_idx = '0;
        for (int i = PROJ_SLOTS - 1; i >= 0; i--) begin
            if (!w_valid_q[i]) begin
                w_any_free = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        req_ready = 2'b00;
        if (w_any_free) begin
            if (req_valid == 2'b11) begin
                req_ready = r_rr_last_q ? 2'b01 : 2'b10;
            end else begin
                req_ready = req_valid;
            end
        end
    end

    always_comb begin
        w_gnt              = req_ready[1];
        w_alloc_en         = (|req_ready) && (req_type[w_gnt] != ATK_RSVD);
        w_rr_last_d        = (|req_ready) ? w_gnt : r_rr_last_q;
        w_alloc_slot.valid = 1'b1;
        w_alloc_slot.owner = w_gnt;
        w_alloc_slot.kind  = req_type[w_gnt];
        w_alloc_slot.x     = req_x[w_gnt];
        w_alloc_slot.y     = req_y[w_gnt];
        w_alloc_slot.w     = req_w[w_gnt];
        w_alloc_slot.h     = req_h[w_gnt];
    end

    generate
        for (genvar gi = 0; gi < PROJ_SLOTS; gi++) begin : g_slot
            proj_slot #(
                .BOSS_SPEED   (BOSS_SPEED),
                .PLAYER_SPEED (PLAYER_SPEED),
                .DIAG_DX      (DIAG_DX),
                .BEAM_LIFE    (BEAM_LIFE)
            ) u_slot (
                .clk          (clk_master),
                .rst_n        (rst_n),
                .i_alloc      (w_alloc_en && (w_free_idx == IDX_W'(gi))),
                .i_alloc_slot (w_alloc_slot),
                .i_alloc_dir  (req_dir[w_gnt]),
                .i_kill       (kill_valid && (kill_idx == IDX_W'(gi))),
                .i_step       (pulse_cycleStep),
                .o_valid_q    (w_valid_q[gi]),
                .o_slot_d     (w_slot_d[gi])
            );
            assign w_valid_d[gi] = w_slot_d[gi].valid;
        end
    endgenerate

    always_comb begin
        w_free_count_d = CNT_W'(PROJ_SLOTS);
        for (int i = 0; i < PROJ_SLOTS; i++) begin
            if (w_valid_d[i]) begin
                w_free_count_d = w_free_count_d - CNT_W'(1);
            end
        end
        w_rd_d = w_slot_d[rd_idx];
        if (!w_rd_d.valid) begin
            w_rd_d = '0;
        end
    end

    always_ff @(posedge clk_master or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last_q    <= 1'b1;
            r_rd_q         <= '0;
            r_free_count_q <= CNT_W'(PROJ_SLOTS);
        end else begin
            r_rr_last_q    <= w_rr_last_d;
            r_rd_q         <= w_rd_d;
            r_free_count_q <= w_free_count_d;
        end
    end

    assign rd_valid    = r_rd_q.valid;
    assign rd_owner    = r_rd_q.owner;
    assign rd_x        = r_rd_q.x;
    assign rd_y        = r_rd_q.y;
    assign rd_w        = r_rd_q.w;
    assign rd_h        = r_rd_q.h;
    assign rd_type     = r_rd_q.kind;
    assign active_mask = w_valid_q;
    assign free_count  = r_free_count_q;

endmodule
`default_nettype wire

// File: tb/tb_projectile_pool_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_projectile_pool_arbiter
// Description : Directed scenarios plus randomized traffic against a
//               behavioural pool model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_projectile_pool_arbiter;

    localparam int SLOTS = 8;

    logic            clk_master = 1'b0;
    logic            rst_n = 1'b0;
    logic            pulse_cycleStep = 1'b0;
    logic [1:0]      req_valid = 2'b00;
    logic [1:0]      req_ready;
    logic [1:0][9:0] req_x = '0;
    logic [1:0][9:0] req_y = '0;
    logic [1:0][9:0] req_w = '0;
    logic [1:0][8:0] req_h = '0;
    logic [1:0][1:0] req_type = '0;
    logic [1:0]      req_dir = '0;
    logic            kill_valid = 1'b0;
    logic [2:0]      kill_idx = '0;
    logic [2:0]      rd_idx = '0;
    logic            rd_valid, rd_owner;
    logic [9:0]      rd_x, rd_y, rd_w;
    logic [8:0]      rd_h;
    logic [1:0]      rd_type;
    logic [7:0]      active_mask;
    logic [3:0]      free_count;

    int n_vec = 0;
    int n_err = 0;

    projectile_pool_arbiter dut (
        .clk_master      (clk_master),
        .rst_n           (rst_n),
        .pulse_cycleStep (pulse_cycleStep),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_x           (req_x),
        .req_y           (req_y),
        .req_w           (req_w),
        .req_h           (req_h),
        .req_type        (req_type),
        .req_dir         (req_dir),
        .kill_valid      (kill_valid),
        .kill_idx        (kill_idx),
        .rd_idx          (rd_idx),
        .rd_valid        (rd_valid),
        .rd_owner        (rd_owner),
        .rd_x            (rd_x),
        .rd_y            (rd_y),
        .rd_w            (rd_w),
        .rd_h            (rd_h),
        .rd_type         (rd_type),
        .active_mask     (active_mask),
        .free_count      (free_count)
    );

    always #5 clk_master = ~clk_master;

    // Behavioural pool: one record per slot, updated with the game rules
    int m_valid [SLOTS];
    int m_owner [SLOTS];
    int m_type  [SLOTS];
    int m_dir   [SLOTS];
    int m_x     [SLOTS];
    int m_y     [SLOTS];
    int m_w     [SLOTS];
    int m_h     [SLOTS];
    int m_life  [SLOTS];
    int m_rr_last;
    int e_valid, e_owner, e_x, e_y, e_w, e_h, e_type;
    logic [1:0] e_ready, g_ready;

    function automatic logic [7:0] model_mask();
        logic [7:0] m = '0;
        for (int i = 0; i < SLOTS; i++) m[i] = (m_valid[i] != 0);
        return m;
    endfunction

    function automatic int model_free();
        int n = 0;
        for (int i = 0; i < SLOTS; i++) if (m_valid[i] == 0) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SLOTS; i++) m_valid[i] = 0;
        m_rr_last = 1;
        e_valid = 0; e_owner = 0; e_x = 0; e_y = 0; e_w = 0; e_h = 0; e_type = 0;
    endtask

    task automatic model_step(input int i);
        int  ny, nx;
        bit  gone;
        if (m_type[i] == 1) begin
            if (m_life[i] == 1) m_valid[i] = 0;
            else m_life[i] = m_life[i] - 1;
        end else if (m_owner[i] == 1) begin
            if (m_y[i] < 35 + 6) m_valid[i] = 0;
            else m_y[i] = m_y[i] - 6;
        end else begin
            ny = m_y[i] + 4;
            nx = m_x[i];
            gone = (ny > 514);
            if (m_type[i] == 2) begin
                nx = m_dir[i] ? m_x[i] + 3 : m_x[i] - 3;
                if (m_dir[i] != 0 && nx + m_w[i] > 783) gone = 1;
                if (m_dir[i] == 0 && nx < 144) gone = 1;
            end
            if (gone) m_valid[i] = 0;
            else begin
                m_x[i] = nx;
                m_y[i] = ny;
            end
        end
    endtask

    task automatic set_req(input int r, input int x, input int y, input int w,
                           input int h, input int t, input int d);
        req_x[r]    = 10'(x);
        req_y[r]    = 10'(y);
        req_w[r]    = 10'(w);
        req_h[r]    = 9'(h);
        req_type[r] = 2'(t);
        req_dir[r]  = 1'(d);
    endtask

    // Applies one clock of stimulus starting at a negedge and ends at the next
    // negedge; leaves DUT grant in g_ready and model predictions in e_*
    task automatic cycle(input logic [1:0] rv, input logic step, input logic kv,
                         input int kidx, input int ridx);
        int free_slot, gi;
        req_valid       = rv;
        pulse_cycleStep = step;
        kill_valid      = kv;
        kill_idx        = 3'(kidx);
        rd_idx          = 3'(ridx);
        #1;
        g_ready   = req_ready;
        free_slot = -1;
        for (int i = 0; i < SLOTS; i++)
            if (m_valid[i] == 0 && free_slot < 0) free_slot = i;
        if (free_slot < 0) e_ready = 2'b00;
        else if (rv == 2'b11) e_ready = (m_rr_last == 1) ? 2'b01 : 2'b10;
        else e_ready = rv;
        gi = (e_ready == 2'b10) ? 1 : 0;
        @(posedge clk_master);
        for (int i = 0; i < SLOTS; i++) begin
            if (m_valid[i] != 0) begin
                if (kv && kidx == i) m_valid[i] = 0;
                else if (step) model_step(i);
            end
        end
        if (e_ready != 2'b00) begin
            m_rr_last = gi;
            if (req_type[gi] != 2'd3) begin
                m_valid[free_slot] = 1;
                m_owner[free_slot] = gi;
                m_type[free_slot]  = int'(req_type[gi]);
                m_dir[free_slot]   = int'(req_dir[gi]);
                m_x[free_slot]     = int'(req_x[gi]);
                m_y[free_slot]     = int'(req_y[gi]);
                m_w[free_slot]     = int'(req_w[gi]);
                m_h[free_slot]     = int'(req_h[gi]);
                m_life[free_slot]  = 30;
            end
        end
        if (m_valid[ridx] != 0) begin
            e_valid = 1; e_owner = m_owner[ridx]; e_x = m_x[ridx]; e_y = m_y[ridx];
            e_w = m_w[ridx]; e_h = m_h[ridx]; e_type = m_type[ridx];
        end else begin
            e_valid = 0; e_owner = 0; e_x = 0; e_y = 0; e_w = 0; e_h = 0; e_type = 0;
        end
        @(negedge clk_master);
        req_valid       = 2'b00;
        pulse_cycleStep = 1'b0;
        kill_valid      = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 2'b00; pulse_cycleStep = 1'b0; kill_valid = 1'b0;
        @(negedge clk_master);
        @(negedge clk_master);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        n_vec++;
        if (active_mask !== 8'h00 || free_count !== 4'd8 || rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state mask=%h free=%0d rd_valid=%b need 00/8/0", active_mask, free_count, rd_valid);
        end
        rst_n = 1'b1;
        model_reset();
        set_req(0, 200, 100, 8, 8, 0, 0);
        repeat (3) cycle(2'b01, 1'b0, 1'b0, 0, 0);
        n_vec++;
        if (active_mask !== 8'h07) begin
            n_err++;
            $display("FAIL reset_prefill mask=%h need 07", active_mask);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (active_mask !== 8'h00 || free_count !== 4'd8 || rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async mask=%h free=%0d rd_valid=%b need 00/8/0", active_mask, free_count, rd_valid);
        end
        for (int i = 0; i < SLOTS; i++) begin
            rd_idx = 3'(i);
            #1;
            n_vec++;
            if (rd_valid !== 1'b0) begin
                n_err++;
                $display("FAIL reset_rd idx=%0d rd_valid=%b need 0", i, rd_valid);
            end
        end
        @(negedge clk_master);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_contention();
        logic [1:0] want [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        set_req(0, 300, 100, 8, 8, 0, 0);
        set_req(1, 400, 400, 8, 8, 0, 0);
        for (int k = 0; k < 4; k++) begin
            cycle(2'b11, 1'b0, 1'b0, 0, 0);
            n_vec++;
            if (g_ready !== want[k]) begin
                n_err++;
                $display("FAIL contention_grant k=%0d got=%b need=%b", k, g_ready, want[k]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            cycle(2'b00, 1'b0, 1'b0, 0, k);
            n_vec++;
            if (rd_valid !== 1'b1 || rd_owner !== 1'(k % 2)) begin
                n_err++;
                $display("FAIL contention_owner slot=%0d valid=%b owner=%b need 1/%0d", k, rd_valid, rd_owner, k % 2);
            end
        end
    endtask

    task automatic test_full_pool();
        do_reset();
        set_req(0, 250, 100, 8, 8, 0, 0);
        for (int k = 0; k < 8; k++) begin
            cycle(2'b01, 1'b0, 1'b0, 0, 0);
            n_vec++;
            if (g_ready !== 2'b01) begin
                n_err++;
                $display("FAIL full_fill k=%0d got=%b need=01", k, g_ready);
            end
        end
        cycle(2'b01, 1'b0, 1'b0, 0, 0);
        n_vec++;
        if (g_ready !== 2'b00 || free_count !== 4'd0) begin
            n_err++;
            $display("FAIL full_ninth ready=%b free=%0d need 00/0", g_ready, free_count);
        end
        cycle(2'b01, 1'b0, 1'b1, 5, 5);
        n_vec++;
        if (g_ready !== 2'b00 || active_mask !== 8'hDF || free_count !== 4'd1) begin
            n_err++;
            $display("FAIL full_kill ready=%b mask=%h free=%0d need 00/df/1", g_ready, active_mask, free_count);
        end
        set_req(0, 555, 120, 8, 8, 0, 0);
        cycle(2'b01, 1'b0, 1'b0, 0, 5);
        n_vec++;
        if (g_ready !== 2'b01 || rd_valid !== 1'b1 || rd_x !== 10'd555 || active_mask !== 8'hFF) begin
            n_err++;
            $display("FAIL full_reuse ready=%b valid=%b x=%0d mask=%h need 01/1/555/ff", g_ready, rd_valid, rd_x, active_mask);
        end
    endtask

    task automatic test_motion();
        do_reset();
        set_req(0, 300, 508, 8, 8, 0, 0);
        cycle(2'b01, 1'b0, 1'b0, 0, 0);
        cycle(2'b00, 1'b1, 1'b0, 0, 0);
        n_vec++;
        if (rd_valid !== 1'b1 || rd_y !== 10'd512) begin
            n_err++;
            $display("FAIL motion_boss1 valid=%b y=%0d need 1/512", rd_valid, rd_y);
        end
        cycle(2'b00, 1'b1, 1'b0, 0, 0);
        n_vec++;
        if (rd_valid !== 1'b0 || active_mask !== 8'h00) begin
            n_err++;
            $display("FAIL motion_boss2 valid=%b mask=%h need 0/00", rd_valid, active_mask);
        end
        set_req(1, 300, 40, 8, 8, 0, 0);
        cycle(2'b10, 1'b0, 1'b0, 0, 0);
        cycle(2'b00, 1'b1, 1'b0, 0, 0);
        n_vec++;
        if (rd_valid !== 1'b0 || free_count !== 4'd8) begin
            n_err++;
            $display("FAIL motion_player valid=%b free=%0d need 0/8", rd_valid, free_count);
        end
    endtask

    task automatic test_beam();
        do_reset();
        set_req(0, 300, 200, 4, 100, 1, 0);
        cycle(2'b01, 1'b0, 1'b0, 0, 0);
        repeat (29) cycle(2'b00, 1'b1, 1'b0, 0, 0);
        n_vec++;
        if (rd_valid !== 1'b1 || rd_y !== 10'd200 || rd_type !== 2'b01) begin
            n_err++;
            $display("FAIL beam_29 valid=%b y=%0d type=%b need 1/200/01", rd_valid, rd_y, rd_type);
        end
        cycle(2'b00, 1'b1, 1'b0, 0, 0);
        n_vec++;
        if (rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL beam_30 valid=%b need 0", rd_valid);
        end
        set_req(0, 300, 200, 4, 100, 1, 0);
        cycle(2'b01, 1'b0, 1'b0, 0, 0);
        cycle(2'b00, 1'b1, 1'b1, 0, 0);
        n_vec++;
        if (rd_valid !== 1'b0 || free_count !== 4'd8) begin
            n_err++;
            $display("FAIL beam_kill_step valid=%b free=%0d need 0/8", rd_valid, free_count);
        end
    endtask

    task automatic test_diag();
        do_reset();
        set_req(0, 770, 100, 10, 8, 2, 1);
        cycle(2'b01, 1'b0, 1'b0, 0, 0);
        cycle(2'b00, 1'b1, 1'b0, 0, 0);
        n_vec++;
        if (rd_valid !== 1'b1 || rd_x !== 10'd773 || rd_y !== 10'd104) begin
            n_err++;
            $display("FAIL diag_right1 valid=%b x=%0d y=%0d need 1/773/104", rd_valid, rd_x, rd_y);
        end
        cycle(2'b00, 1'b1, 1'b0, 0, 0);
        n_vec++;
        if (rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL diag_right2 valid=%b need 0", rd_valid);
        end
        set_req(0, 150, 100, 10, 8, 2, 0);
        cycle(2'b01, 1'b0, 1'b0, 0, 0);
        repeat (2) cycle(2'b00, 1'b1, 1'b0, 0, 0);
        n_vec++;
        if (rd_valid !== 1'b1 || rd_x !== 10'd144) begin
            n_err++;
            $display("FAIL diag_left_edge valid=%b x=%0d need 1/144", rd_valid, rd_x);
        end
        cycle(2'b00, 1'b1, 1'b0, 0, 0);
        n_vec++;
        if (rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL diag_left_out valid=%b need 0", rd_valid);
        end
    endtask

    task automatic test_random();
        int w;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < 2; r++) begin
                w = $urandom_range(1, 80);
                set_req(r, $urandom_range(144, 700), $urandom_range(35, 514), w,
                        $urandom_range(0, 511), $urandom_range(0, 3), $urandom_range(0, 1));
            end
            cycle(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0), $urandom_range(0, 7), $urandom_range(0, 7));
            n_vec++;
            if (g_ready !== e_ready) begin
                n_err++;
                $display("FAIL rand_ready c=%0d got=%b need=%b", c, g_ready, e_ready);
            end
            n_vec++;
            if (active_mask !== model_mask() || free_count !== 4'(model_free())) begin
                n_err++;
                $display("FAIL rand_pool c=%0d mask=%h free=%0d need %h/%0d", c, active_mask, free_count, model_mask(), model_free());
            end
            n_vec++;
            if (rd_valid !== 1'(e_valid) || rd_owner !== 1'(e_owner) || rd_x !== 10'(e_x) ||
                rd_y !== 10'(e_y) || rd_w !== 10'(e_w) || rd_h !== 9'(e_h) || rd_type !== 2'(e_type)) begin
                n_err++;
                $display("FAIL rand_rd c=%0d got v%b o%b x%0d y%0d w%0d h%0d t%0d need v%0d o%0d x%0d y%0d w%0d h%0d t%0d",
                         c, rd_valid, rd_owner, rd_x, rd_y, rd_w, rd_h, rd_type,
                         e_valid, e_owner, e_x, e_y, e_w, e_h, e_type);
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk_master);
        test_reset();
        test_contention();
        test_full_pool();
        test_motion();
        test_beam();
        test_diag();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
